// File: rtl/xgpon_burst_framer.sv
// XG-PON upstream burst framer on the AXI-Stream Ethernet path.
// Wraps each frame in preamble, delimiter and optional trailer, then holds a guard gap.
module xgpon_burst_framer #(
    parameter int          DATA_W         = 32,
    parameter int          PREAMBLE_WORDS = 3,
    parameter logic [31:0] PREAMBLE_PAT   = 32'h05560556,
    parameter logic [31:0] DELIM_PAT      = 32'hB2C50FA1,
    parameter bit          TRAILER_EN     = 1'b1,
    parameter logic [31:0] TRAILER_PAT    = 32'hAAAAAAAA,
    parameter int          GAP_CYCLES     = 4
) (
    input  logic                  axis_clk,
    input  logic                  axis_resetn,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic [31:0]           frame_count
);

    localparam int LANES = DATA_W / 32;
    localparam logic [DATA_W-1:0] PRE_D = {LANES{PREAMBLE_PAT}};
    localparam logic [DATA_W-1:0] DLM_D = {LANES{DELIM_PAT}};
    localparam logic [DATA_W-1:0] TRL_D = {LANES{TRAILER_PAT}};
    localparam logic [7:0] PW_LAST = 8'(PREAMBLE_WORDS - 1);
    localparam logic [7:0] GAP_N   = 8'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DELIM,
        S_PAYLOAD,
        S_TRAILER,
        S_GAP
    } state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic [7:0] gap_cnt;
    logic       load;

    assign load          = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == S_PAYLOAD) && load;

    always_ff @(posedge axis_clk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state         <= S_IDLE;
            beat_cnt      <= 8'd0;
            gap_cnt       <= 8'd0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_count   <= 32'd0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                frame_count <= frame_count + 32'd1;

            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        m_axis_tvalid <= s_axis_tvalid;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        if (s_axis_tvalid) begin
                            m_axis_tdata <= PRE_D;
                            m_axis_tkeep <= '1;
                            beat_cnt     <= 8'd1;
                            state        <= (PW_LAST == 8'd0) ? S_DELIM
                                                              : S_PREAMBLE;
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (load) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= PRE_D;
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        beat_cnt      <= beat_cnt + 8'd1;
                        if (beat_cnt == PW_LAST)
                            state <= S_DELIM;
                    end
                end

                S_DELIM: begin
                    if (load) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= DLM_D;
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                        beat_cnt      <= 8'd0;
                        state         <= S_PAYLOAD;
                    end
                end

                S_PAYLOAD: begin
                    if (load) begin
                        m_axis_tvalid <= s_axis_tvalid;
                        if (s_axis_tvalid) begin
                            m_axis_tdata <= s_axis_tdata;
                            m_axis_tkeep <= s_axis_tkeep;
                            m_axis_tuser <= s_axis_tuser;
                            m_axis_tlast <= !TRAILER_EN && s_axis_tlast;
                            if (s_axis_tlast) begin
                                gap_cnt <= 8'd0;
                                state   <= TRAILER_EN ? S_TRAILER : S_GAP;
                            end
                        end
                    end
                end

                S_TRAILER: begin
                    if (load) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= TRL_D;
                        m_axis_tkeep  <= '1;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= 1'b0;
                        gap_cnt       <= 8'd0;
                        state         <= S_GAP;
                    end
                end

                S_GAP: begin
                    // load here means the tlast beat has left or is leaving now
                    if (load) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        if (gap_cnt == GAP_N) begin
                            gap_cnt <= 8'd0;
                            state   <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgpon_burst_framer.sv
// Bench for xgpon_burst_framer: random frames vs a burst-level reference model.
// A second 64-bit, trailer-less instance gets a short directed run.
module tb_xgpon_burst_framer;

    localparam int PW  = 3;
    localparam int GAP = 4;
    localparam logic [31:0] PRE = 32'h05560556;
    localparam logic [31:0] DLM = 32'hB2C50FA1;
    localparam logic [31:0] TRL = 32'hAAAAAAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_valid, s_last, s_user, s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid, m_last, m_user, m_ready;
    logic [31:0] fcnt;

    logic [63:0] b_s_data;
    logic [7:0]  b_s_keep;
    logic        b_s_valid, b_s_last, b_s_user, b_s_ready;
    logic [63:0] b_m_data;
    logic [7:0]  b_m_keep;
    logic        b_m_valid, b_m_last, b_m_user, b_m_ready;
    logic [31:0] b_fcnt;

    xgpon_burst_framer dut (
        .axis_clk      (clk),
        .axis_resetn   (rst_n),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tuser  (s_user),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tuser  (m_user),
        .m_axis_tready (m_ready),
        .frame_count   (fcnt)
    );

    xgpon_burst_framer #(
        .DATA_W         (64),
        .PREAMBLE_WORDS (2),
        .TRAILER_EN     (1'b0),
        .GAP_CYCLES     (0)
    ) dut_b (
        .axis_clk      (clk),
        .axis_resetn   (rst_n),
        .s_axis_tdata  (b_s_data),
        .s_axis_tkeep  (b_s_keep),
        .s_axis_tvalid (b_s_valid),
        .s_axis_tlast  (b_s_last),
        .s_axis_tuser  (b_s_user),
        .s_axis_tready (b_s_ready),
        .m_axis_tdata  (b_m_data),
        .m_axis_tkeep  (b_m_keep),
        .m_axis_tvalid (b_m_valid),
        .m_axis_tlast  (b_m_last),
        .m_axis_tuser  (b_m_user),
        .m_axis_tready (b_m_ready),
        .frame_count   (b_fcnt)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        u;
        logic        l;
    } beat_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        u;
        logic        l;
    } bbeat_t;

    beat_t  src_q[$];
    beat_t  exp_q[$];
    bbeat_t bsrc[$];
    bbeat_t bexp[$];

    int n_chk = 0;
    int n_pass = 0;

    int    out_n, in_cnt, cyc, last_hs_cyc, frames_sent, vmode;
    bit    in_active, burst_open, have_last, exact_gap;
    bit    prev_stall, pend_in, rand_rdy;
    beat_t saved;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        src_q.delete();
        exp_q.delete();
        out_n      = 0;
        in_cnt     = 0;
        in_active  = 0;
        burst_open = 0;
        have_last  = 0;
        prev_stall = 0;
        pend_in    = 0;
        frames_sent = 0;
    endtask

    task automatic add_frame(input int len);
        beat_t b;
        for (int i = 0; i < PW; i++) exp_q.push_back({PRE, 4'hF, 1'b0, 1'b0});
        exp_q.push_back({DLM, 4'hF, 1'b0, 1'b0});
        for (int i = 0; i < len; i++) begin
            b.d = $urandom;
            b.k = (i == len - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
            b.u = 1'($urandom_range(0, 1));
            b.l = (i == len - 1);
            src_q.push_back(b);
            exp_q.push_back({b.d, b.k, b.u, 1'b0});
        end
        exp_q.push_back({TRL, 4'hF, 1'b0, 1'b1});
        frames_sent++;
    endtask

    task automatic monitor();
        beat_t o;
        o = {m_data, m_keep, m_user, m_last};
        cyc++;
        if (prev_stall)
            chk("stall_hold", 128'({m_valid, o}), 128'({1'b1, saved}));
        if (m_valid && !burst_open) begin
            burst_open = 1;
            if (have_last) begin
                if (exact_gap)
                    chk("gap_exact", 128'(cyc - last_hs_cyc), 128'(GAP + 2));
                else
                    chk("gap_min", 128'((cyc - last_hs_cyc) >= GAP + 2), 128'(1));
            end
        end
        if (m_valid && m_ready) begin
            chk("exp_avail", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) chk("beat", 128'(o), 128'(exp_q.pop_front()));
            out_n++;
            if (out_n == PW + 1) in_active = 1;
            if (m_last) begin
                out_n       = 0;
                burst_open  = 0;
                have_last   = 1;
                last_hs_cyc = cyc;
            end
        end
        chk("s_ready", 128'(s_ready), 128'(in_active && (!m_valid || m_ready)));
        pend_in = s_valid && s_ready;
        if (pend_in) begin
            in_cnt++;
            if (s_last) begin
                in_active = 0;
                in_cnt    = 0;
            end
        end
        prev_stall = m_valid && !m_ready;
        saved      = o;
    endtask

    task automatic drive();
        bit en;
        if (pend_in) void'(src_q.pop_front());
        pend_in = 0;
        unique case (vmode)
            1:       en = 1'b1;
            2:       en = (cyc % 2) == 0;
            default: en = $urandom_range(0, 3) != 0;
        endcase
        s_valid = (src_q.size() > 0) && en;
        if (src_q.size() > 0) begin
            s_data = src_q[0].d;
            s_keep = src_q[0].k;
            s_user = src_q[0].u;
            s_last = src_q[0].l;
        end else begin
            s_data = $urandom;
            s_keep = 4'($urandom);
            s_user = 1'b1;
            s_last = 1'b1;
        end
        m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 128'(n < budget), 128'(1));
        repeat (GAP + 3) tick();
    endtask

    task automatic run_b();
        bbeat_t bb;
        bit     b_open, b_have, b_hs;
        int     bl_cyc, n;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 2; i++) bexp.push_back({{PRE, PRE}, 8'hFF, 1'b0, 1'b0});
            bexp.push_back({{DLM, DLM}, 8'hFF, 1'b0, 1'b0});
            for (int i = 0; i < 3; i++) begin
                bb.d = {$urandom, $urandom};
                bb.k = (i == 2) ? 8'h0F : 8'hFF;
                bb.u = 1'($urandom_range(0, 1));
                bb.l = (i == 2);
                bsrc.push_back(bb);
                bexp.push_back(bb);
            end
        end
        b_open = 0;
        b_have = 0;
        bl_cyc = 0;
        b_hs   = 0;
        n      = 0;
        while ((bexp.size() > 0 || b_m_valid) && n < 200) begin
            @(negedge clk);
            if (b_m_valid && !b_open) begin
                b_open = 1;
                if (b_have) chk("b_gap", 128'(n - bl_cyc), 128'(2));
            end
            if (b_m_valid && b_m_ready) begin
                chk("b_avail", 128'(bexp.size() > 0), 128'(1));
                if (bexp.size() > 0)
                    chk("b_beat", 128'({b_m_data, b_m_keep, b_m_user, b_m_last}),
                        128'(bexp.pop_front()));
                if (b_m_last) begin
                    b_open = 0;
                    b_have = 1;
                    bl_cyc = n;
                end
            end
            b_hs = b_s_valid && b_s_ready;
            @(posedge clk);
            #1;
            if (b_hs) void'(bsrc.pop_front());
            b_s_valid = bsrc.size() > 0;
            if (bsrc.size() > 0) begin
                b_s_data = bsrc[0].d;
                b_s_keep = bsrc[0].k;
                b_s_user = bsrc[0].u;
                b_s_last = bsrc[0].l;
            end
            n++;
        end
        chk("b_timeout", 128'(n < 200), 128'(1));
        repeat (3) @(posedge clk);
        chk("b_fcnt", 128'(b_fcnt), 128'(2));
    endtask

    initial begin
        rst_n     = 1'b0;
        s_data    = '0;
        s_keep    = '0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_user    = 1'b0;
        m_ready   = 1'b1;
        b_s_data  = '0;
        b_s_keep  = '0;
        b_s_valid = 1'b0;
        b_s_last  = 1'b0;
        b_s_user  = 1'b0;
        b_m_ready = 1'b1;
        cyc       = 0;
        last_hs_cyc = 0;
        exact_gap = 0;
        rand_rdy  = 0;
        vmode     = 1;
        saved     = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 128'({m_valid, m_last, m_user, m_data, m_keep, s_ready}), 128'(0));
        chk("rst_fcnt", 128'(fcnt), 128'(0));
        rst_n = 1'b1;

        // single 5-beat frame, first preamble beat one cycle after tvalid
        exact_gap = 1;
        add_frame(5);
        drive();
        chk("lat_c0", 128'(m_valid), 128'(0));
        tick();
        chk("lat_c1", 128'({m_valid, m_data, m_last}), 128'({1'b1, PRE, 1'b0}));
        drain(500);
        chk("fcnt_1", 128'(fcnt), 128'(1));

        // randomized backpressure and source gaps
        exact_gap = 0;
        rand_rdy  = 1;
        vmode     = 0;
        for (int f = 0; f < 100; f++) add_frame($urandom_range(1, 64));
        drain(40000);
        chk("fcnt_101", 128'(fcnt), 128'(frames_sent));

        // back-to-back frames, tvalid held: exact guard spacing
        rand_rdy  = 0;
        vmode     = 1;
        exact_gap = 1;
        have_last = 0;
        for (int f = 0; f < 4; f++) add_frame($urandom_range(1, 8));
        drain(1000);
        chk("fcnt_b2b", 128'(fcnt), 128'(frames_sent));

        // reset during the third payload beat
        exact_gap = 0;
        add_frame(8);
        begin
            int n;
            n = 0;
            while (in_cnt < 2 && n < 200) begin
                tick();
                n++;
            end
            chk("reach_beat3", 128'(n < 200), 128'(1));
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 128'({m_valid, m_last, m_user, m_data, m_keep, s_ready}), 128'(0));
        chk("rst_mid_fcnt", 128'(fcnt), 128'(0));
        model_reset();
        s_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_frame(3);
        drive();
        drain(500);
        chk("fcnt_after_rst", 128'(fcnt), 128'(1));

        // single-beat frames with tvalid toggling through the preamble
        vmode = 2;
        for (int f = 0; f < 3; f++) add_frame(1);
        drain(500);
        chk("fcnt_single", 128'(fcnt), 128'(frames_sent));

        run_b();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
